// File: rtl/timer_interrupt_controller.sv
// ============================================================================
// timer_interrupt_controller - timer IRQ arbitration and entry sequencing
// Rev 1.0
// ============================================================================
`default_nettype none

module timer_interrupt_controller #(
    parameter int                  PC_WIDTH      = 14,
    parameter logic [PC_WIDTH-1:0] VECTOR_BASE   = PC_WIDTH'('h008),
    parameter int                  VECTOR_STRIDE = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          irq_flags,
    input  logic [7:0]          irq_mask,
    input  logic                global_ie,
    input  logic                instr_boundary,
    input  logic                reti,
    input  logic [PC_WIDTH-1:0] pc_current,
    output logic                busy,
    output logic [7:0]          push_data,
    output logic                push_we,
    output logic                sp_dec,
    output logic [PC_WIDTH-1:0] pc_new,
    output logic                pc_load,
    output logic                clear_ie,
    output logic                set_ie,
    output logic [7:0]          flag_clear
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PUSH_LO = 2'd1,
        S_PUSH_HI = 2'd2,
        S_VECTOR  = 2'd3
    } state_t;

    state_t                state_q;
    logic [2:0]            winner_q;
    logic [PC_WIDTH-1:0]   ret_q;
    logic                  block_next_q;

    logic [7:0]            w_pending;
    logic [2:0]            w_win_idx;
    logic [PC_WIDTH-1:0]   w_vector;

    assign w_pending = irq_flags & irq_mask;

    // Ascending scan so the highest set bit is the last to overwrite.
    always_comb begin
        w_win_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (w_pending[i]) begin
                w_win_idx = 3'(i);
            end
        end
    end

    assign w_vector = VECTOR_BASE
                    + PC_WIDTH'(VECTOR_STRIDE) * PC_WIDTH'(3'd7 - winner_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            winner_q     <= 3'd0;
            ret_q        <= '0;
            block_next_q <= 1'b0;
            busy         <= 1'b0;
            push_data    <= 8'h00;
            push_we      <= 1'b0;
            sp_dec       <= 1'b0;
            pc_new       <= '0;
            pc_load      <= 1'b0;
            clear_ie     <= 1'b0;
            set_ie       <= 1'b0;
            flag_clear   <= 8'h00;
        end else begin
            push_data  <= 8'h00;
            push_we    <= 1'b0;
            sp_dec     <= 1'b0;
            pc_load    <= 1'b0;
            clear_ie   <= 1'b0;
            set_ie     <= 1'b0;
            flag_clear <= 8'h00;
            case (state_q)
                S_IDLE: begin
                    // RETI outranks a dispatch and arms the one-instruction shadow.
                    if (reti) begin
                        set_ie       <= 1'b1;
                        block_next_q <= 1'b1;
                    end else if (instr_boundary) begin
                        if (block_next_q) begin
                            block_next_q <= 1'b0;
                        end else if (global_ie && (|w_pending)) begin
                            winner_q  <= w_win_idx;
                            ret_q     <= pc_current;
                            state_q   <= S_PUSH_LO;
                            busy      <= 1'b1;
                            push_data <= pc_current[7:0];
                            push_we   <= 1'b1;
                            sp_dec    <= 1'b1;
                        end
                    end
                end
                S_PUSH_LO: begin
                    state_q   <= S_PUSH_HI;
                    push_data <= 8'(ret_q >> 8);
                    push_we   <= 1'b1;
                    sp_dec    <= 1'b1;
                end
                S_PUSH_HI: begin
                    state_q    <= S_VECTOR;
                    pc_new     <= w_vector;
                    pc_load    <= 1'b1;
                    clear_ie   <= 1'b1;
                    flag_clear <= 8'h01 << winner_q;
                end
                S_VECTOR: begin
                    state_q <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/timer_interrupt_controller.md
Name: timer_interrupt_controller

Overview:
- Arbitrates the eight timer interrupt sources, TIFR bits 7..0, against the TIMSK enable bits and the SREG I-bit.
- Sequences interrupt entry at an instruction boundary:
  - pushes the 14-bit return PC onto the stack as two bytes;
  - loads the program memory PC with the winning vector;
  - clears the I-bit;
  - clears the serviced TIFR flag.
- Sits between the timers/SREG and the control unit, stack pointer, memory map and program memory PC-overwrite path.

Parameters:
- PC_WIDTH, 14, program counter width in words.
- VECTOR_BASE, 14'h008, vector of TIFR bit 7 (OCF2).
- VECTOR_STRIDE, 2, word distance between consecutive vectors.

Ports:
- clk  input  1  system clock (16 MHz).
- rst  input  1  asynchronous reset, active-high.
- irq_flags  input  8  TIFR contents.
- irq_mask  input  8  TIMSK contents.
- global_ie  input  1  SREG bit 7 (I).
- instr_boundary  input  1  one-cycle pulse from the control unit when the next instruction fetch may be replaced.
- reti  input  1  one-cycle pulse when RETI completes.
- pc_current  input  PC_WIDTH  return address to save.
- busy  output  1  control unit must stall fetch and decode while high.
- push_data  output  8  byte to write at the current SP.
- push_we  output  1  memory write strobe for push_data.
- sp_dec  output  1  decrement SP by 1 (same cycle as push_we).
- pc_new  output  PC_WIDTH  vector address.
- pc_load  output  1  PC overwrite strobe.
- clear_ie  output  1  clear SREG I-bit strobe.
- set_ie  output  1  set SREG I-bit strobe (RETI).
- flag_clear  output  8  one-hot TIFR bit to clear (write-1-to-clear).

Behaviour:
- Reset: state IDLE; all outputs 0; latched winner, return PC and block_next cleared. Reset mid-sequence aborts it with no further strobes.
- pending = irq_flags & irq_mask.
- Priority: highest set bit of pending wins (bit 7 highest).
- Vector = VECTOR_BASE + VECTOR_STRIDE*(7-bit). Bit 4 (OCF1A) -> 0x00E; bit 0 (TOV0) -> 0x016.
- Dispatch condition in IDLE: instr_boundary & global_ie & |pending & !block_next & !reti.
  - On dispatch: latch winner index and pc_current; go to PUSH_LO.
- States:
  - IDLE -> PUSH_LO on dispatch.
  - PUSH_LO: push_data = ret[7:0], push_we = 1, sp_dec = 1 -> PUSH_HI.
  - PUSH_HI: push_data = {2'b0, ret[13:8]}, push_we = 1, sp_dec = 1 -> VECTOR.
  - VECTOR: pc_new = vector, pc_load = 1, clear_ie = 1, flag_clear = one-hot(winner) -> IDLE.
- Latency: boundary at cycle N; strobes at N+1, N+2, N+3; busy high N+1..N+3; new dispatch possible from N+4.
- All strobes are single-cycle registered outputs. pc_new holds its value after VECTOR until the next dispatch; push_data is 0 outside the push states.
- RETI:
  - reti in IDLE -> set_ie = 1 the next cycle and block_next = 1.
  - block_next suppresses dispatch at the next instr_boundary, so one main-program instruction always executes; that boundary then clears block_next.
  - reti coincident with a dispatch condition: reti wins and no dispatch occurs.
  - reti while busy: ignored.
- Inputs change during the sequence:
  - Winner flag drops mid-sequence: sequence still completes with the latched vector and flag_clear.
  - global_ie or irq_mask change mid-sequence: no effect.
  - instr_boundary while busy: ignored.
- Multiple pending: only the winner is serviced and flagged; the others remain pending and are taken at the next eligible boundary after the handler re-enables I.
- pending = 0 or global_ie = 0: boundary pulses produce no activity.

Test Plan:
- Reset then idle: rst pulse mid-PUSH_HI -> all outputs 0 next cycle; no pc_load follows.
- Single source: flags = 8'h10, mask = 8'h10, ie = 1, pc_current = 14'h1234, boundary at N.
  - N+1: push 8'h34, push_we, sp_dec.
  - N+2: push 8'h12, push_we, sp_dec.
  - N+3: pc_new = 14'h00E, pc_load, clear_ie, flag_clear = 8'h10.
- Priority: flags = 8'h13, mask = 8'hFF -> vector 14'h00E, flag_clear = 8'h10.
  - After reti and one further boundary, the next dispatch gives 14'h014 with flag_clear 8'h02.
- Masking and I-bit:
  - flags = 8'h01, mask = 8'h00, ie = 1 -> no activity.
  - mask = 8'h01, ie = 0 -> no activity.
  - ie = 1 -> vector 14'h016.
- RETI shadow: reti then an immediate boundary with pending = 8'h04 -> set_ie, no dispatch. The following boundary -> dispatch to 14'h012.
- Flag withdrawn: flags 8'h04 -> 8'h00 at N+1 -> full sequence still completes, pc_new = 14'h012, flag_clear = 8'h04.
